vga_timing_gen_param: RTL and testbench

Parametrised VGA raster timing generator and pixel output stage, successor to the fixed 640x480 controller. Generates H/V sync with configurable porches and polarity, a pixel-request strobe with configurable lead, and pixel coordinates. Drives the board DAC with registered, blank-gated colour and an optional frame-latched grayscale mode. Sits between the frame-buffer/SDRAM read path and the VGA DAC pins.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_gray_conv.sv | 15 +
 rtl/vga_timing_gen_param.sv | 174 +++++++++++++++++
 tb/tb_vga_timing_gen_param.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), coordinate widths and the
// helper that turns a porch/sync/active set into a total period.
package vga_pkg;
    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int CNT_W = 16;

    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_H_ACT   = 640;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 33;
    localparam int DEF_V_ACT   = 480;
    localparam int DEF_V_FRONT = 10;

    function automatic int vga_total(input int sync_w, input int back_w,
                                     input int act_w, input int front_w);
        return sync_w + back_w + act_w + front_w;
    endfunction
endpackage

// File: rtl/vga_gray_conv.sv
// Combinational RGB to gray reducer: (R + 2G + B) >> 2 with two guard
// bits so the sum never overflows before the shift.
module vga_gray_conv #(
    parameter int COLOR_W = 10
) (
    input  logic [COLOR_W-1:0] i_r,
    input  logic [COLOR_W-1:0] i_g,
    input  logic [COLOR_W-1:0] i_b,
    output logic [COLOR_W-1:0] o_gray
);
    logic [COLOR_W+1:0] w_sum;

    assign w_sum  = {2'b00, i_r} + {1'b0, i_g, 1'b0} + {2'b00, i_b};
    assign o_gray = w_sum[COLOR_W+1:2];
endmodule

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA raster generator: free-running h/v counters feed
// registered sync, blank, pixel request/coordinates and gated DAC colour.
module vga_timing_gen_param
    import vga_pkg::*;
#(
    parameter int COLOR_W  = 10,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int H_ACT    = DEF_H_ACT,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_ACT    = DEF_V_ACT,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int REQ_LEAD = 2
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iGray,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic               oRequest,
    output logic [X_W-1:0]     oX,
    output logic [Y_W-1:0]     oY,
    output logic               oFrameStart,
    output logic               oLineStart,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLOCK
);
    localparam int H_TOTAL = vga_total(H_SYNC, H_BACK, H_ACT, H_FRONT);
    localparam int V_TOTAL = vga_total(V_SYNC, V_BACK, V_ACT, V_FRONT);

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] X_START_C = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] X_END_C   = CNT_W'(H_SYNC + H_BACK + H_ACT);
    localparam logic [CNT_W-1:0] Y_START_C = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] Y_END_C   = CNT_W'(V_SYNC + V_BACK + V_ACT);
    localparam logic [CNT_W-1:0] LEAD_C    = CNT_W'(REQ_LEAD);
    localparam logic             H_ON      = 1'(H_POL);
    localparam logic             V_ON      = 1'(V_POL);

    logic [CNT_W-1:0]   r_h_cnt;
    logic [CNT_W-1:0]   r_v_cnt;
    logic               r_req;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic               r_frame_start;
    logic               r_line_start;
    logic               r_hs;
    logic               r_vs;
    logic               r_blank;
    logic               r_gray_mode;
    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;

    logic               w_h_act;
    logic               w_v_act;
    logic               w_blank;
    logic [CNT_W-1:0]   w_h_lead;
    logic               w_req;
    logic               w_origin;
    logic [COLOR_W-1:0] w_gray;
    logic [COLOR_W-1:0] w_r;
    logic [COLOR_W-1:0] w_g;
    logic [COLOR_W-1:0] w_b;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    assign w_h_act  = (r_h_cnt >= X_START_C) && (r_h_cnt < X_END_C);
    assign w_v_act  = (r_v_cnt >= Y_START_C) && (r_v_cnt < Y_END_C);
    assign w_blank  = w_h_act && w_v_act;
    // Request window is the active window shifted earlier by REQ_LEAD; the
    // lead never exceeds X_START so no wrap handling is needed.
    assign w_h_lead = r_h_cnt + LEAD_C;
    assign w_req    = (w_h_lead >= X_START_C) && (w_h_lead < X_END_C) && w_v_act;
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

    vga_gray_conv #(
        .COLOR_W (COLOR_W)
    ) u_gray (
        .i_r    (iRed),
        .i_g    (iGreen),
        .i_b    (iBlue),
        .o_gray (w_gray)
    );

    always_comb begin
        w_r = iRed;
        w_g = iGreen;
        w_b = iBlue;
        if (r_gray_mode) begin
            w_r = w_gray;
            w_g = w_gray;
            w_b = w_gray;
        end
        if (!w_blank) begin
            w_r = '0;
            w_g = '0;
            w_b = '0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_req         <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_hs          <= ~H_ON;
            r_vs          <= ~V_ON;
            r_blank       <= 1'b0;
            r_gray_mode   <= 1'b0;
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
        end else begin
            r_req         <= w_req;
            r_frame_start <= w_origin;
            r_line_start  <= (r_h_cnt == '0);
            r_hs          <= (r_h_cnt < H_SYNC_C) ? H_ON : ~H_ON;
            r_vs          <= (r_v_cnt < V_SYNC_C) ? V_ON : ~V_ON;
            r_blank       <= w_blank;
            r_r           <= w_r;
            r_g           <= w_g;
            r_b           <= w_b;
            if (w_req) begin
                r_x <= X_W'(w_h_lead - X_START_C);
                r_y <= Y_W'(r_v_cnt - Y_START_C);
            end
            // Mode only changes at the raster origin so a frame is never mixed.
            if (w_origin) begin
                r_gray_mode <= iGray;
            end
        end
    end

    assign oRequest    = r_req;
    assign oX          = r_x;
    assign oY          = r_y;
    assign oFrameStart = r_frame_start;
    assign oLineStart  = r_line_start;
    assign oVGA_H_SYNC = r_hs;
    assign oVGA_V_SYNC = r_vs;
    assign oVGA_BLANK  = r_blank;
    assign oVGA_R      = r_r;
    assign oVGA_G      = r_g;
    assign oVGA_B      = r_b;
    assign oVGA_SYNC   = 1'b0;
    assign oVGA_CLOCK  = iCLK;
endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Directed bench for vga_timing_gen_param on a 16x8 raster, with an
// active-low sync build and an active-high sync build side by side.
module tb_vga_timing_gen_param;
    localparam int CW = 10;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iGray = 1'b0;
    logic [CW-1:0] iRed = '0;
    logic [CW-1:0] iGreen = '0;
    logic [CW-1:0] iBlue = '0;

    logic          oRequest, oFrameStart, oLineStart;
    logic [10:0]   oX;
    logic [9:0]    oY;
    logic [CW-1:0] oVGA_R, oVGA_G, oVGA_B;
    logic          oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC, oVGA_CLOCK;

    logic          p_req, p_fs, p_ls;
    logic [10:0]   p_x;
    logic [9:0]    p_y;
    logic [CW-1:0] p_r, p_g, p_b;
    logic          p_hs, p_vs, p_blank, p_sync, p_clock;

    vga_timing_gen_param #(
        .COLOR_W(CW), .H_SYNC(3), .H_BACK(3), .H_ACT(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(1), .V_ACT(4), .V_FRONT(1),
        .H_POL(0), .V_POL(0), .REQ_LEAD(2)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iGray(iGray),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oRequest(oRequest), .oX(oX), .oY(oY),
        .oFrameStart(oFrameStart), .oLineStart(oLineStart),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC),
        .oVGA_BLANK(oVGA_BLANK), .oVGA_SYNC(oVGA_SYNC), .oVGA_CLOCK(oVGA_CLOCK)
    );

    vga_timing_gen_param #(
        .COLOR_W(CW), .H_SYNC(3), .H_BACK(3), .H_ACT(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(1), .V_ACT(4), .V_FRONT(1),
        .H_POL(1), .V_POL(1), .REQ_LEAD(2)
    ) dut_p (
        .iCLK(iCLK), .iRST_N(iRST_N), .iGray(iGray),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oRequest(p_req), .oX(p_x), .oY(p_y),
        .oFrameStart(p_fs), .oLineStart(p_ls),
        .oVGA_R(p_r), .oVGA_G(p_g), .oVGA_B(p_b),
        .oVGA_H_SYNC(p_hs), .oVGA_V_SYNC(p_vs),
        .oVGA_BLANK(p_blank), .oVGA_SYNC(p_sync), .oVGA_CLOCK(p_clock)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int gray_from_k = 0;
    int pipe_val = 0;
    int req_rise = 0;
    logic prev_req = 1'b0;
    logic prev_blank = 1'b0;
    logic [10:0] exp_x = '0;
    logic [9:0]  exp_y = '0;
    int hs_low, vs_low, blank_cnt, req_cnt, fs_cnt, ls_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        hs_low = 0; vs_low = 0; blank_cnt = 0; req_cnt = 0; fs_cnt = 0; ls_cnt = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, {31'd0, oRequest}, 0);
        check({tag, "_x"}, {21'd0, oX}, 0);
        check({tag, "_y"}, {22'd0, oY}, 0);
        check({tag, "_fs"}, {31'd0, oFrameStart}, 0);
        check({tag, "_ls"}, {31'd0, oLineStart}, 0);
        check({tag, "_r"}, {22'd0, oVGA_R}, 0);
        check({tag, "_g"}, {22'd0, oVGA_G}, 0);
        check({tag, "_b"}, {22'd0, oVGA_B}, 0);
        check({tag, "_blank"}, {31'd0, oVGA_BLANK}, 0);
        check({tag, "_hs"}, {31'd0, oVGA_H_SYNC}, 1);
        check({tag, "_vs"}, {31'd0, oVGA_V_SYNC}, 1);
        check({tag, "_hs_pos"}, {31'd0, p_hs}, 0);
        check({tag, "_vs_pos"}, {31'd0, p_vs}, 0);
        check({tag, "_sync"}, {31'd0, oVGA_SYNC}, 0);
    endtask

    // mode 0: pixel source answering oRequest one cycle late
    // mode 1: constant 0x3FF on all inputs
    // mode 2: 0x100/0x200/0x300, gray after gray_from_k
    task automatic cycle(input int mode);
        int h, v, ec_r, ec_g, ec_b;
        logic e_blank, e_req;
        @(posedge iCLK);
        #1;
        h = k % 16;
        v = (k / 16) % 8;
        e_blank = (h >= 6) && (h < 14) && (v >= 3) && (v < 7);
        e_req   = (h + 2 >= 6) && (h + 2 < 14) && (v >= 3) && (v < 7);
        if (e_req) begin
            exp_x = 11'(h + 2 - 6);
            exp_y = 10'(v - 3);
        end
        check("hsync", {31'd0, oVGA_H_SYNC}, (h < 3) ? 0 : 1);
        check("vsync", {31'd0, oVGA_V_SYNC}, (v < 2) ? 0 : 1);
        check("hsync_pos", {31'd0, p_hs}, (h < 3) ? 1 : 0);
        check("vsync_pos", {31'd0, p_vs}, (v < 2) ? 1 : 0);
        check("blank", {31'd0, oVGA_BLANK}, {31'd0, e_blank});
        check("request", {31'd0, oRequest}, {31'd0, e_req});
        check("x", {21'd0, oX}, {21'd0, exp_x});
        check("y", {22'd0, oY}, {22'd0, exp_y});
        check("frame_start", {31'd0, oFrameStart}, (h == 0 && v == 0) ? 1 : 0);
        check("line_start", {31'd0, oLineStart}, (h == 0) ? 1 : 0);

        ec_r = 0; ec_g = 0; ec_b = 0;
        if (e_blank) begin
            if (mode == 0) begin
                ec_r = (v - 3) * 16 + (h - 6); ec_g = ec_r; ec_b = ec_r;
            end else if (mode == 1) begin
                ec_r = 'h3FF; ec_g = 'h3FF; ec_b = 'h3FF;
            end else if (k >= gray_from_k) begin
                ec_r = 'h200; ec_g = 'h200; ec_b = 'h200;
            end else begin
                ec_r = 'h100; ec_g = 'h200; ec_b = 'h300;
            end
        end
        check("red", {22'd0, oVGA_R}, ec_r);
        check("green", {22'd0, oVGA_G}, ec_g);
        check("blue", {22'd0, oVGA_B}, ec_b);

        if (oRequest && !prev_req) req_rise = k;
        if (oVGA_BLANK && !prev_blank) check("req_lead", k - req_rise, 2);
        prev_req = oRequest;
        prev_blank = oVGA_BLANK;

        if (!oVGA_H_SYNC) hs_low++;
        if (!oVGA_V_SYNC) vs_low++;
        if (oVGA_BLANK) blank_cnt++;
        if (oRequest) req_cnt++;
        if (oFrameStart) fs_cnt++;
        if (oLineStart) ls_cnt++;

        if (mode == 0) begin
            iRed = CW'(pipe_val);
            iGreen = CW'(pipe_val);
            iBlue = CW'(pipe_val);
            if (oRequest) pipe_val = int'(oX) + 16 * int'(oY);
        end
        k++;
    endtask

    initial begin
        repeat (2) @(posedge iCLK);
        #1;
        check_reset("cold_reset");
        iRST_N = 1'b1;
        k = 0;

        // Two frames with a pixel source: timing, alignment and counts.
        clear_stats();
        repeat (256) cycle(0);
        check("hs_low_2frames", hs_low, 48);
        check("vs_low_2frames", vs_low, 64);
        check("blank_2frames", blank_cnt, 64);
        check("req_2frames", req_cnt, 64);
        check("fs_2frames", fs_cnt, 2);
        check("ls_2frames", ls_cnt, 16);

        // Full-scale inputs also during blanking.
        iRed = 'h3FF; iGreen = 'h3FF; iBlue = 'h3FF;
        clear_stats();
        repeat (128) cycle(1);
        check("req_frame_3ff", req_cnt, 32);
        check("blank_frame_3ff", blank_cnt, 32);

        // Grayscale requested mid-frame; applies from the next frame.
        iRed = 'h100; iGreen = 'h200; iBlue = 'h300;
        gray_from_k = k + 128;
        repeat (60) cycle(2);
        iGray = 1'b1;
        repeat (68 + 128) cycle(2);

        // Reset while the counters sit at h=5, v=2.
        repeat (37) cycle(2);
        iRST_N = 1'b0;
        #1;
        check_reset("async_reset");
        repeat (3) @(posedge iCLK);
        #1;
        check_reset("held_reset");
        iRST_N = 1'b1;
        k = 0;
        exp_x = '0;
        exp_y = '0;
        prev_req = 1'b0;
        prev_blank = 1'b0;
        gray_from_k = 0;
        clear_stats();
        repeat (128) cycle(2);
        check("fs_after_reset", fs_cnt, 1);
        check("hs_low_after_reset", hs_low, 24);
        check("req_after_reset", req_cnt, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
